obi_mailbox_responder: RTL and testbench

OBI responder (memory-side end of the core's instruction/data OBI port) implementing a small word-addressed mailbox register bank with programmable grant wait-states and fixed response latency. It sits on the system bus behind the crossbar as a slave target. Word 0 doubles as a doorbell whose non-zero content drives an interrupt line back toward the CPU subsystem's `irq_i`.

---
 rtl/obi_mailbox_responder.sv | 100 ++++++++++
 tb/tb_obi_mailbox_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/obi_mailbox_responder.sv
// obi_mailbox_responder: OBI mailbox register bank with grant wait-states, fixed response latency and doorbell irq
package obi_mailbox_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_mailbox_responder
  import obi_mailbox_pkg::*;
#(
  parameter int          NumWords      = 16,
  parameter logic [31:0] BaseAddr      = 32'h0,
  parameter int          GntWaitCycles = 0,
  parameter int          RespLatency   = 1,
  parameter logic [31:0] OorRdata      = 32'hBADCAB1E
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  obi_req_i,
  output obi_resp_t obi_resp_o,
  output logic      irq_o
);
  localparam int IW = $clog2(NumWords);
  localparam logic [31:0] Mask = 32'(NumWords * 4 - 1);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_n;
  logic [2:0] wcnt, wcnt_n;
  logic gnt, fire, hit, wr;
  logic [IW-1:0] idx;
  logic [31:0] regs [NumWords];
  logic [31:0] wmerge, rd;
  logic [RespLatency-1:0] pv;
  logic [31:0] pd [RespLatency];
  assign hit  = (obi_req_i.addr & ~Mask) == BaseAddr;
  assign idx  = obi_req_i.addr[2 +: IW];
  assign fire = obi_req_i.req & gnt;
  assign wr   = fire & obi_req_i.we & hit;
  assign rd   = hit ? regs[idx] : OorRdata;
  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    gnt     = 1'b0;
    if (state == IDLE) begin
      if (obi_req_i.req && GntWaitCycles == 0) gnt = 1'b1;
      else if (obi_req_i.req) begin
        state_n = WAIT;
        wcnt_n  = 3'd1;
      end
    end else if (!obi_req_i.req || wcnt == 3'(GntWaitCycles)) begin
      gnt     = obi_req_i.req;
      state_n = IDLE;
      wcnt_n  = '0;
    end else wcnt_n = wcnt + 3'd1;
    if (rst_i) gnt = 1'b0;
  end
  always_comb begin
    wmerge = regs[idx];
    for (int b = 0; b < 4; b++)
      wmerge[8*b +: 8] = obi_req_i.be[b] ? obi_req_i.wdata[8*b +: 8] : regs[idx][8*b +: 8];
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      wcnt  <= '0;
      irq_o <= 1'b0;
      for (int i = 0; i < NumWords; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      irq_o <= |((wr && idx == '0) ? wmerge : regs[0]);
      if (wr) regs[idx] <= wmerge;
    end
  end
  // Data only advances alongside a valid bit so the last stage holds its value while idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pv <= '0;
      for (int i = 0; i < RespLatency; i++) pd[i] <= '0;
    end else begin
      pv[0] <= fire;
      pd[0] <= fire ? (obi_req_i.we ? '0 : rd) : pd[0];
      for (int i = RespLatency - 1; i > 0; i--) begin
        pv[i] <= pv[i-1];
        pd[i] <= pv[i-1] ? pd[i-1] : pd[i];
      end
    end
  end
  assign obi_resp_o.gnt    = gnt;
  assign obi_resp_o.rvalid = pv[RespLatency-1];
  assign obi_resp_o.rdata  = pd[RespLatency-1];
endmodule

// File: tb/tb_obi_mailbox_responder.sv
// tb_obi_mailbox_responder: directed scoreboard bench over four parameterisations of the mailbox
module tb_obi_mailbox_responder;
  import obi_mailbox_pkg::*;
  localparam int GW[4] = '{0, 3, 0, 1};
  localparam int LT[4] = '{1, 4, 2, 3};
  localparam logic [31:0] BA[4] = '{32'h0, 32'h0, 32'h100, 32'h0};
  localparam logic [31:0] OOR = 32'hBADCAB1E;
  typedef struct {
    int          dut;
    logic [31:0] data;
    int          due;
  } exp_t;
  logic clk = 1'b0;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  obi_req_t  req [4];
  obi_resp_t resp [4];
  logic irq [4];
  logic rst [4];
  logic [31:0] mdl [4][16];
  exp_t sb [$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    obi_mailbox_responder #(
      .NumWords(16), .BaseAddr(BA[g]), .GntWaitCycles(GW[g]),
      .RespLatency(LT[g]), .OorRdata(OOR)
    ) u_dut (
      .clk_i(clk), .rst_i(rst[g]), .obi_req_i(req[g]),
      .obi_resp_o(resp[g]), .irq_o(irq[g])
    );
  end
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic xact(int d, logic we, logic [3:0] be, logic [31:0] addr, logic [31:0] wdata, bit push = 1);
    logic in_range;
    logic [3:0] w;
    logic [31:0] e;
    for (int i = 0; i <= GW[d]; i++) begin
      @(negedge clk);
      req[d] = '{req: 1'b1, we: we, be: be, addr: addr, wdata: wdata};
      #1;
      check($sformatf("gnt d%0d wait%0d", d, i), 32'(resp[d].gnt), 32'(i == GW[d]));
    end
    in_range = (addr & ~32'h3F) == BA[d];
    w = addr[5:2];
    e = we ? 32'h0 : (in_range ? mdl[d][w] : OOR);
    if (push) sb.push_back('{d, e, cyc + LT[d]});
    if (we && in_range)
      for (int b = 0; b < 4; b++) if (be[b]) mdl[d][w][8*b +: 8] = wdata[8*b +: 8];
  endtask
  task automatic idle(int d);
    @(negedge clk);
    req[d].req = 1'b0;
    #1;
    check($sformatf("gnt_idle d%0d", d), 32'(resp[d].gnt), 32'h0);
    check($sformatf("irq d%0d", d), 32'(irq[d]), 32'(|mdl[d][0]));
  endtask
  task automatic drain(int d);
    idle(d);
    for (int k = 0; k < 8 && sb.size() > 0; k++) idle(d);
    check("drain", sb.size(), 0);
  endtask
  // Scoreboard: every rvalid must match the oldest expected response, on its due cycle
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 4; d++) if (resp[d].rvalid) begin
      if (sb.size() == 0) check($sformatf("rvalid_unexpected d%0d", d), 32'(sb.size()), 32'h1);
      else begin
        e = sb.pop_front();
        check("rsp_dut", d, e.dut);
        check($sformatf("rsp_data d%0d", d), resp[d].rdata, e.data);
        check($sformatf("rsp_cycle d%0d", d), cyc, e.due);
      end
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      check("rsp_missing", cyc, sb[0].due);
      void'(sb.pop_front());
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    for (int d = 0; d < 4; d++) begin
      req[d] = '0;
      rst[d] = 1'b1;
      for (int i = 0; i < 16; i++) mdl[d][i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check("rst_gnt", 32'(resp[d].gnt), 32'h0);
      check("rst_rvalid", 32'(resp[d].rvalid), 32'h0);
      check("rst_rdata", resp[d].rdata, 32'h0);
      check("rst_irq", 32'(irq[d]), 32'h0);
      rst[d] = 1'b0;
    end
    // Zero wait states, latency 1: write then read, byte enables, out-of-range, doorbell
    xact(0, 1, 4'hF, 32'd12, 32'hDEADBEEF);
    xact(0, 0, 4'hF, 32'd12, 32'h0);
    drain(0);
    xact(0, 1, 4'hF, 32'd20, 32'h11223344);
    xact(0, 1, 4'b0101, 32'd20, 32'hAABBCCDD);
    xact(0, 0, 4'hF, 32'd21, 32'h0);
    drain(0);
    xact(0, 0, 4'hF, 32'd64, 32'h0);
    xact(0, 1, 4'hF, 32'd64, 32'hFFFFFFFF);
    xact(0, 0, 4'hF, 32'd0, 32'h0);
    drain(0);
    xact(0, 1, 4'hF, 32'd0, 32'h1);
    idle(0);
    xact(0, 1, 4'hF, 32'd0, 32'h0);
    drain(0);
    // Three wait states, latency 4, including an abandoned request
    xact(1, 0, 4'hF, 32'd8, 32'h0);
    drain(1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req[1] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 32'd8, wdata: 32'h0};
      #1;
      check("gnt_abort", 32'(resp[1].gnt), 32'h0);
    end
    idle(1);
    xact(1, 1, 4'hF, 32'd8, 32'hCAFEF00D);
    xact(1, 0, 4'hF, 32'd8, 32'h0);
    drain(1);
    // Latency 2 at a non-zero base: back-to-back reads
    for (int i = 0; i < 4; i++) xact(2, 1, 4'hF, 32'h100 + 32'(4 * i), 32'(i + 1));
    drain(2);
    for (int i = 0; i < 4; i++) xact(2, 0, 4'hF, 32'h100 + 32'(4 * i), 32'h0);
    drain(2);
    check("rdata_hold", resp[2].rdata, mdl[2][3]);
    xact(2, 0, 4'hF, 32'h0, 32'h0);
    drain(2);
    // Latency 3: reset one cycle after a read grant drops its response
    xact(3, 1, 4'hF, 32'd0, 32'h5);
    drain(3);
    xact(3, 0, 4'hF, 32'd8, 32'h0, 0);
    @(negedge clk);
    rst[3] = 1'b1;
    req[3] = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 32'd4, wdata: 32'h7};
    #1;
    check("gnt_in_rst", 32'(resp[3].gnt), 32'h0);
    @(negedge clk);
    rst[3] = 1'b0;
    req[3].req = 1'b0;
    for (int i = 0; i < 16; i++) mdl[3][i] = '0;
    #1;
    check("post_rst_rdata", resp[3].rdata, 32'h0);
    check("post_rst_irq", 32'(irq[3]), 32'h0);
    repeat (5) idle(3);
    xact(3, 0, 4'hF, 32'd0, 32'h0);
    xact(3, 0, 4'hF, 32'd4, 32'h0);
    drain(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
